id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Parametrised, registered instruction-decode stage between IF and EX.
//  Decodes ORI/ANDI/XORI/LUI plus SPECIAL AND/OR/XOR/NOR/ADDU/SUBU/SLL/SRL/SRA.
//  Drives regfile read ports and selects operands (register or immediate).
//  Holds results in an ID/EX register with valid/ready handshake, flush and optional forwarding.
// PARAMETERS
//  DATA_W     32  datapath / operand width (>=16; imm extended to DATA_W)
//  REG_AW      5  register address width
//  ALU_OP_W    8  alu_op_o width
//  ALU_SEL_W   3  alu_sel_o width
// PORTS
//  clk              in   1          clock, all state on rising edge
//  rst              in   1          synchronous reset, active-low
//  flush_i          in   1          kill ID/EX contents (branch/exception)
//  in_valid_i       in   1          pc_i/inst_i valid from IF
//  in_ready_o       out  1          stage can accept an instruction this cycle
//  pc_i             in   DATA_W     instruction address
//  inst_i           in   32         instruction word
//  reg1_read_en_o   out  1          regfile port1 enable (comb.)
//  reg1_read_addr_o out  REG_AW     = inst_i[25:21] (comb.)
//  reg2_read_en_o   out  1          regfile port2 enable (comb.)
//  reg2_read_addr_o out  REG_AW     = inst_i[20:16] (comb.)
//  reg1_data_i      in   DATA_W     regfile port1 data (same cycle)
//  reg2_data_i      in   DATA_W     regfile port2 data (same cycle)
//  ex_wen_i/ex_waddr_i/ex_wdata_i    in 1/REG_AW/DATA_W  EX-stage result
//  mem_wen_i/mem_waddr_i/mem_wdata_i in 1/REG_AW/DATA_W  MEM-stage result
//  out_valid_o      out  1          ID/EX register holds an instruction
//  out_ready_i      in   1          EX accepts it this cycle
//  pc_o             out  DATA_W     registered pc
//  alu_op_o         out  ALU_OP_W   registered ALU sub-op
//  alu_sel_o        out  ALU_SEL_W  registered ALU class
//  op_number_1_o    out  DATA_W     registered operand 1
//  op_number_2_o    out  DATA_W     registered operand 2
//  write_reg_en_o   out  1          registered writeback enable
//  write_reg_addr_o out  REG_AW     registered writeback address
//  inst_invalid_o   out  1          registered: unknown opcode
// BEHAVIOUR
//  Decode (comb.): ORI/ANDI/XORI zero-ext imm, LUI {imm,16'h0}; op1=rs, op2=imm, rd=rt.
//  SPECIAL logic/arith: op1=rs, op2=rt, rd=inst[15:11]. Shifts: op1=rt, op2=zero-ext sa.
//  alu_sel: 000 NOP, 001 LOGIC, 010 SHIFT, 011 ARITH. alu_op: AND 24, OR 25, XOR 26,
//   NOR 27, LUI 0F, ADDU 21, SUBU 23, SLL 7C, SRL 02, SRA 03 (hex).
//  Unknown opcode: NOP, write_reg_en=0, both read_en=0, inst_invalid=1, still occupies a slot.
//  Disabled read port: operand = extended immediate (0 if none).
//  in_ready_o = rst & ~flush_i & (~out_valid_o | out_ready_i).
//  Edge, priority order:
//   1. ~rst: every registered output = 0.
//   2. flush_i: out_valid_o<=0; other regs don't-care, held.
//   3. in_ready_o: out_valid_o<=in_valid_i; when in_valid_i, load all fields.
//   4. else hold all registers (EX stall).
//  Latency 1 cycle; full throughput when out_ready_i=1.
//  Reg addr 0 always reads as 0 (never forwarded).
//  Flush and in_valid_i same cycle: instruction dropped, in_ready_o=0.
// CONFIGURATION
//  ID_FORWARD_EN defined: operand priority EX (wen & waddr==addr & addr!=0), then MEM, then regfile.
//  Undefined: operands taken from reg*_data_i only; ex_*/mem_* inputs ignored.
// TESTING
//  1. rst=0 two cycles -> all outputs 0, in_ready_o=0; release -> in_ready_o=1.
//  2. ORI $2,$1,0x00FF, reg1=0x12340000 -> next cycle valid, op1=0x12340000,
//     op2=0x000000FF, alu_op=25, sel=001, waddr=2.
//  3. out_ready_i=0 three cycles with second instr queued -> ID/EX held, in_ready_o=0;
//     ready=1 -> second instr loads next edge.
//  4. ID_FORWARD_EN: ADDU $3,$1,$2; ex writes $1=5, mem writes $1=7 & $2=9, regfile 0
//     -> op1=5, op2=9. Undefined -> op1=0, op2=0.
//  5. flush_i with valid ORI -> out_valid_o=0 next cycle; opcode 6'h3F -> inst_invalid=1, wen=0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// Registered MIPS-subset decode stage: regfile read, operand select, ID/EX register with valid/ready and flush.
// Latency 1 cycle; stalls (holds ID/EX, drops in_ready_o) while out_ready_i is low. Optional macro: ID_FORWARD_EN.
module id_stage_pipe #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int ALU_OP_W  = 8,
    parameter int ALU_SEL_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DATA_W-1:0]    pc_i,
    input  logic [31:0]          inst_i,
    output logic                 reg1_read_en_o,
    output logic [REG_AW-1:0]    reg1_read_addr_o,
    output logic                 reg2_read_en_o,
    output logic [REG_AW-1:0]    reg2_read_addr_o,
    input  logic [DATA_W-1:0]    reg1_data_i,
    input  logic [DATA_W-1:0]    reg2_data_i,
    input  logic                 ex_wen_i,
    input  logic [REG_AW-1:0]    ex_waddr_i,
    input  logic [DATA_W-1:0]    ex_wdata_i,
    input  logic                 mem_wen_i,
    input  logic [REG_AW-1:0]    mem_waddr_i,
    input  logic [DATA_W-1:0]    mem_wdata_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATA_W-1:0]    pc_o,
    output logic [ALU_OP_W-1:0]  alu_op_o,
    output logic [ALU_SEL_W-1:0] alu_sel_o,
    output logic [DATA_W-1:0]    op_number_1_o,
    output logic [DATA_W-1:0]    op_number_2_o,
    output logic                 write_reg_en_o,
    output logic [REG_AW-1:0]    write_reg_addr_o,
    output logic                 inst_invalid_o
);

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_ANDI    = 6'h0C;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_XORI    = 6'h0E;
    localparam logic [5:0] OPC_LUI     = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(8'h24);
    localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(8'h25);
    localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(8'h26);
    localparam logic [ALU_OP_W-1:0] OP_NOR  = ALU_OP_W'(8'h27);
    localparam logic [ALU_OP_W-1:0] OP_LUI  = ALU_OP_W'(8'h0F);
    localparam logic [ALU_OP_W-1:0] OP_ADDU = ALU_OP_W'(8'h21);
    localparam logic [ALU_OP_W-1:0] OP_SUBU = ALU_OP_W'(8'h23);
    localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(8'h7C);
    localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(8'h02);
    localparam logic [ALU_OP_W-1:0] OP_SRA  = ALU_OP_W'(8'h03);

    localparam logic [ALU_SEL_W-1:0] SEL_NOP   = ALU_SEL_W'(3'b000);
    localparam logic [ALU_SEL_W-1:0] SEL_LOGIC = ALU_SEL_W'(3'b001);
    localparam logic [ALU_SEL_W-1:0] SEL_SHIFT = ALU_SEL_W'(3'b010);
    localparam logic [ALU_SEL_W-1:0] SEL_ARITH = ALU_SEL_W'(3'b011);

    logic [5:0]          opcode, funct;
    logic [REG_AW-1:0]   rt_addr, rd_addr;
    logic [DATA_W-1:0]   imm_zext, imm_lui, sa_zext;

    assign opcode   = inst_i[31:26];
    assign funct    = inst_i[5:0];
    assign rt_addr  = REG_AW'(inst_i[20:16]);
    assign rd_addr  = REG_AW'(inst_i[15:11]);
    assign imm_zext = DATA_W'(inst_i[15:0]);
    assign imm_lui  = DATA_W'({inst_i[15:0], 16'h0000});
    assign sa_zext  = DATA_W'(inst_i[10:6]);

    assign reg1_read_addr_o = REG_AW'(inst_i[25:21]);
    assign reg2_read_addr_o = rt_addr;

    logic [ALU_OP_W-1:0]  dec_op;
    logic [ALU_SEL_W-1:0] dec_sel;
    logic                 dec_wen, dec_shift, dec_inv;
    logic [REG_AW-1:0]    dec_waddr;
    logic [DATA_W-1:0]    dec_imm, dec_op1, dec_op2;
    logic [DATA_W-1:0]    rs1_val, rs2_val;

    always_comb begin
        dec_op         = '0;
        dec_sel        = SEL_NOP;
        reg1_read_en_o = 1'b0;
        reg2_read_en_o = 1'b0;
        dec_wen        = 1'b0;
        dec_waddr      = '0;
        dec_imm        = '0;
        dec_shift      = 1'b0;
        dec_inv        = 1'b0;
        case (opcode)
            OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LUI: begin
                dec_sel        = SEL_LOGIC;
                reg1_read_en_o = 1'b1;
                dec_wen        = 1'b1;
                dec_waddr      = rt_addr;
                dec_imm        = imm_zext;
                case (opcode)
                    OPC_ANDI: dec_op = OP_AND;
                    OPC_ORI:  dec_op = OP_OR;
                    OPC_XORI: dec_op = OP_XOR;
                    default: begin
                        dec_op  = OP_LUI;
                        dec_imm = imm_lui;
                    end
                endcase
            end
            OPC_SPECIAL: begin
                reg1_read_en_o = 1'b1;
                reg2_read_en_o = 1'b1;
                dec_wen        = 1'b1;
                dec_waddr      = rd_addr;
                case (funct)
                    FN_AND:  begin dec_sel = SEL_LOGIC; dec_op = OP_AND;  end
                    FN_OR:   begin dec_sel = SEL_LOGIC; dec_op = OP_OR;   end
                    FN_XOR:  begin dec_sel = SEL_LOGIC; dec_op = OP_XOR;  end
                    FN_NOR:  begin dec_sel = SEL_LOGIC; dec_op = OP_NOR;  end
                    FN_ADDU: begin dec_sel = SEL_ARITH; dec_op = OP_ADDU; end
                    FN_SUBU: begin dec_sel = SEL_ARITH; dec_op = OP_SUBU; end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        // shifts operate on rt by the sa field; rs is not read
                        dec_sel        = SEL_SHIFT;
                        reg1_read_en_o = 1'b0;
                        dec_shift      = 1'b1;
                        dec_imm        = sa_zext;
                        dec_op         = (funct == FN_SLL) ? OP_SLL :
                                         (funct == FN_SRL) ? OP_SRL : OP_SRA;
                    end
                    default: begin
                        reg1_read_en_o = 1'b0;
                        reg2_read_en_o = 1'b0;
                        dec_wen        = 1'b0;
                        dec_waddr      = '0;
                        dec_inv        = 1'b1;
                    end
                endcase
            end
            default: dec_inv = 1'b1;
        endcase
    end

`ifdef ID_FORWARD_EN
    // Youngest producer wins: EX result is newer than MEM, which is newer than the regfile.
    always_comb begin
        rs1_val = reg1_data_i;
        if (reg1_read_addr_o == '0)
            rs1_val = '0;
        else if (ex_wen_i && ex_waddr_i == reg1_read_addr_o)
            rs1_val = ex_wdata_i;
        else if (mem_wen_i && mem_waddr_i == reg1_read_addr_o)
            rs1_val = mem_wdata_i;
    end

    always_comb begin
        rs2_val = reg2_data_i;
        if (reg2_read_addr_o == '0)
            rs2_val = '0;
        else if (ex_wen_i && ex_waddr_i == reg2_read_addr_o)
            rs2_val = ex_wdata_i;
        else if (mem_wen_i && mem_waddr_i == reg2_read_addr_o)
            rs2_val = mem_wdata_i;
    end
`else
    assign rs1_val = (reg1_read_addr_o == '0) ? '0 : reg1_data_i;
    assign rs2_val = (reg2_read_addr_o == '0) ? '0 : reg2_data_i;

    logic unused_fwd;
    assign unused_fwd = ^{ex_wen_i, ex_waddr_i, ex_wdata_i, mem_wen_i, mem_waddr_i, mem_wdata_i};
`endif

    always_comb begin
        dec_op1 = reg1_read_en_o ? rs1_val : dec_imm;
        dec_op2 = reg2_read_en_o ? rs2_val : dec_imm;
        if (dec_shift) begin
            dec_op1 = rs2_val;
            dec_op2 = dec_imm;
        end
    end

    assign in_ready_o = rst & ~flush_i & (~out_valid_o | out_ready_i);

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_o      <= 1'b0;
            pc_o             <= '0;
            alu_op_o         <= '0;
            alu_sel_o        <= '0;
            op_number_1_o    <= '0;
            op_number_2_o    <= '0;
            write_reg_en_o   <= 1'b0;
            write_reg_addr_o <= '0;
            inst_invalid_o   <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (in_ready_o) begin
            out_valid_o <= in_valid_i;
            if (in_valid_i) begin
                pc_o             <= pc_i;
                alu_op_o         <= dec_op;
                alu_sel_o        <= dec_sel;
                op_number_1_o    <= dec_op1;
                op_number_2_o    <= dec_op2;
                write_reg_en_o   <= dec_wen;
                write_reg_addr_o <= dec_waddr;
                inst_invalid_o   <= dec_inv;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus randomized traffic against an ISA-level model.
module tb_id_stage_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush_i, in_valid_i, in_ready_o, out_ready_i;
    logic [31:0] pc_i, inst_i;
    logic        reg1_read_en_o, reg2_read_en_o;
    logic [4:0]  reg1_read_addr_o, reg2_read_addr_o;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic        ex_wen_i, mem_wen_i;
    logic [4:0]  ex_waddr_i, mem_waddr_i;
    logic [31:0] ex_wdata_i, mem_wdata_i;
    logic        out_valid_o, write_reg_en_o, inst_invalid_o;
    logic [31:0] pc_o, op_number_1_o, op_number_2_o;
    logic [7:0]  alu_op_o;
    logic [2:0]  alu_sel_o;
    logic [4:0]  write_reg_addr_o;

`ifdef ID_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        wen;
        logic [4:0]  waddr;
        logic        inv;
    } idex_t;

    idex_t exp_r = '0;
    idex_t obs;
    logic [31:0] rf [32];
    int n_chk = 0;
    int n_pass = 0;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .inst_i(inst_i),
        .reg1_read_en_o(reg1_read_en_o), .reg1_read_addr_o(reg1_read_addr_o),
        .reg2_read_en_o(reg2_read_en_o), .reg2_read_addr_o(reg2_read_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wen_i(ex_wen_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .mem_wen_i(mem_wen_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .pc_o(pc_o), .alu_op_o(alu_op_o), .alu_sel_o(alu_sel_o),
        .op_number_1_o(op_number_1_o), .op_number_2_o(op_number_2_o),
        .write_reg_en_o(write_reg_en_o), .write_reg_addr_o(write_reg_addr_o),
        .inst_invalid_o(inst_invalid_o)
    );

    // Regfile answers whatever address the stage presents.
    always_comb begin
        reg1_data_i = rf[reg1_read_addr_o];
        reg2_data_i = rf[reg2_read_addr_o];
    end

    assign obs = {out_valid_o, pc_o, alu_op_o, alu_sel_o, op_number_1_o, op_number_2_o,
                  write_reg_en_o, write_reg_addr_o, inst_invalid_o};

    // Architectural value of register a as seen by an instruction in ID.
    function automatic logic [31:0] src(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (FWD && ex_wen_i && ex_waddr_i == a) return ex_wdata_i;
        if (FWD && mem_wen_i && mem_waddr_i == a) return mem_wdata_i;
        return rf[a];
    endfunction

    function automatic idex_t decode(input logic [31:0] inst, input logic [31:0] pc);
        idex_t d = '0;
        logic [4:0]  rs = inst[25:21];
        logic [4:0]  rt = inst[20:16];
        logic [4:0]  rd = inst[15:11];
        logic [5:0]  fn = inst[5:0];
        logic [31:0] imm = {16'h0, inst[15:0]};
        d.valid = 1'b1;
        d.pc    = pc;
        case (inst[31:26])
            6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                d.sel = 3'd1; d.wen = 1'b1; d.waddr = rt;
                d.op1 = src(rs); d.op2 = imm;
                case (inst[31:26])
                    6'h0C:   d.op = 8'h24;
                    6'h0D:   d.op = 8'h25;
                    6'h0E:   d.op = 8'h26;
                    default: begin d.op = 8'h0F; d.op2 = imm << 16; end
                endcase
            end
            6'h00: begin
                if (fn == 6'h24 || fn == 6'h25 || fn == 6'h26 || fn == 6'h27 ||
                    fn == 6'h21 || fn == 6'h23) begin
                    d.op = {2'b00, fn}; d.sel = (fn[5:2] == 4'b1001) ? 3'd1 : 3'd3;
                    d.op1 = src(rs); d.op2 = src(rt); d.wen = 1'b1; d.waddr = rd;
                end else if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) begin
                    d.op = (fn == 6'h00) ? 8'h7C : {2'b00, fn}; d.sel = 3'd2;
                    d.op1 = src(rt); d.op2 = {27'h0, inst[10:6]}; d.wen = 1'b1; d.waddr = rd;
                end else begin
                    d.inv = 1'b1;
                end
            end
            default: d.inv = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic model_ready();
        return rst && !flush_i && (!exp_r.valid || out_ready_i);
    endfunction

    // Advance one clock, updating the model from inputs held across the edge.
    task automatic tick();
        idex_t nxt = exp_r;
        if (!rst)                nxt = '0;
        else if (flush_i)        nxt.valid = 1'b0;
        else if (model_ready())  nxt = in_valid_i ? decode(inst_i, pc_i) : '0 | (exp_r & ~115'h0) & {1'b0, {114{1'b1}}};
        @(posedge clk);
        exp_r = nxt;
        @(negedge clk);
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 13);
        w[25:21] = 5'($urandom_range(0, 7));
        w[20:16] = 5'($urandom_range(0, 7));
        w[15:11] = 5'($urandom_range(0, 7));
        case (k)
            0: w[31:26] = 6'h0C;
            1: w[31:26] = 6'h0D;
            2: w[31:26] = 6'h0E;
            3: w[31:26] = 6'h0F;
            4: begin w[31:26] = 6'h00; w[5:0] = 6'h24; end
            5: begin w[31:26] = 6'h00; w[5:0] = 6'h25; end
            6: begin w[31:26] = 6'h00; w[5:0] = 6'h26; end
            7: begin w[31:26] = 6'h00; w[5:0] = 6'h27; end
            8: begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
            9: begin w[31:26] = 6'h00; w[5:0] = 6'h23; end
            10: begin w[31:26] = 6'h00; w[5:0] = 6'h00; end
            11: begin w[31:26] = 6'h00; w[5:0] = 6'h02; end
            12: begin w[31:26] = 6'h00; w[5:0] = 6'h03; end
            default: ;
        endcase
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b0; flush_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b1;
        pc_i = 32'h0000_0040; inst_i = {6'h0D, 5'd1, 5'd2, 16'h00FF};
        ex_wen_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0;
        mem_wen_i = 1'b0; mem_waddr_i = '0; mem_wdata_i = '0;
        tick(); tick();
        n_chk++;
        if (obs !== '0) $display("FAIL reset_outputs got %h exp 0", obs);
        else n_pass++;
        n_chk++;
        if (in_ready_o !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready_o);
        else n_pass++;
        rst = 1'b1; in_valid_i = 1'b0;
        #1;
        n_chk++;
        if (in_ready_o !== 1'b1) $display("FAIL release_in_ready got %b exp 1", in_ready_o);
        else n_pass++;
    endtask

    task automatic test_ori();
        rf[1] = 32'h1234_0000;
        pc_i = 32'h0000_0100; inst_i = {6'h0D, 5'd1, 5'd2, 16'h00FF};
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        #1;
        n_chk++;
        if ({reg1_read_en_o, reg1_read_addr_o, reg2_read_en_o} !== {1'b1, 5'd1, 1'b0})
            $display("FAIL ori_read_ports got %b/%0d/%b exp 1/1/0",
                     reg1_read_en_o, reg1_read_addr_o, reg2_read_en_o);
        else n_pass++;
        tick();
        in_valid_i = 1'b0;
        n_chk++;
        if ({out_valid_o, op_number_1_o, op_number_2_o, alu_op_o, alu_sel_o, write_reg_en_o, write_reg_addr_o}
            !== {1'b1, 32'h1234_0000, 32'h0000_00FF, 8'h25, 3'b001, 1'b1, 5'd2})
            $display("FAIL ori_fields got v=%b op1=%h op2=%h op=%h sel=%b we=%b wa=%0d exp 1/12340000/000000ff/25/001/1/2",
                     out_valid_o, op_number_1_o, op_number_2_o, alu_op_o, alu_sel_o, write_reg_en_o, write_reg_addr_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_stall();
        idex_t first;
        rf[1] = 32'h0F0F_1111; rf[2] = 32'h00FF_2222;
        pc_i = 32'h0000_0200; inst_i = {6'h0C, 5'd0, 5'd4, 16'h1234};
        in_valid_i = 1'b1; out_ready_i = 1'b0;
        tick();
        first = exp_r;
        n_chk++;
        if (obs !== first || op_number_1_o !== 32'h0)
            $display("FAIL stall_first_load got %h exp %h", obs, first);
        else n_pass++;
        pc_i = 32'h0000_0204; inst_i = {6'h00, 5'd1, 5'd2, 5'd5, 5'd0, 6'h26};
        for (int c = 0; c < 3; c++) begin
            #1;
            n_chk++;
            if (in_ready_o !== 1'b0) $display("FAIL stall_in_ready cycle %0d got %b exp 0", c, in_ready_o);
            else n_pass++;
            tick();
            n_chk++;
            if (obs !== first) $display("FAIL stall_hold cycle %0d got %h exp %h", c, obs, first);
            else n_pass++;
        end
        out_ready_i = 1'b1;
        #1;
        n_chk++;
        if (in_ready_o !== 1'b1) $display("FAIL stall_release_ready got %b exp 1", in_ready_o);
        else n_pass++;
        tick();
        n_chk++;
        if (obs !== exp_r || pc_o !== 32'h0000_0204 || op_number_1_o !== 32'h0F0F_1111)
            $display("FAIL stall_second_load got %h exp %h", obs, exp_r);
        else n_pass++;
        in_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_forward();
        rf[1] = 32'h0; rf[2] = 32'h0;
        pc_i = 32'h0000_0300; inst_i = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        ex_wen_i = 1'b1; ex_waddr_i = 5'd1; ex_wdata_i = 32'd5;
        mem_wen_i = 1'b1; mem_waddr_i = 5'd1; mem_wdata_i = 32'd7;
        tick();
        n_chk++;
        if (op_number_1_o !== (FWD ? 32'd5 : 32'd0))
            $display("FAIL fwd_ex_over_mem got %0d exp %0d", op_number_1_o, FWD ? 5 : 0);
        else n_pass++;
        mem_waddr_i = 5'd2; mem_wdata_i = 32'd9;
        tick();
        n_chk++;
        if ({op_number_1_o, op_number_2_o} !== (FWD ? {32'd5, 32'd9} : 64'd0))
            $display("FAIL fwd_addu got op1=%0d op2=%0d fwd=%b", op_number_1_o, op_number_2_o, FWD);
        else n_pass++;
        // register 0 must never pick up a forwarded value
        inst_i = {6'h00, 5'd0, 5'd0, 5'd6, 5'd0, 6'h25};
        ex_waddr_i = 5'd0; ex_wdata_i = 32'hAA; mem_waddr_i = 5'd0; mem_wdata_i = 32'hBB;
        tick();
        n_chk++;
        if ({op_number_1_o, op_number_2_o} !== 64'd0 || obs !== exp_r)
            $display("FAIL fwd_reg0 got op1=%h op2=%h exp 0/0", op_number_1_o, op_number_2_o);
        else n_pass++;
        ex_wen_i = 1'b0; mem_wen_i = 1'b0; in_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_flush_invalid();
        pc_i = 32'h0000_0400; inst_i = {6'h0D, 5'd1, 5'd2, 16'h00FF};
        in_valid_i = 1'b1; out_ready_i = 1'b1; flush_i = 1'b1;
        #1;
        n_chk++;
        if (in_ready_o !== 1'b0) $display("FAIL flush_in_ready got %b exp 0", in_ready_o);
        else n_pass++;
        tick();
        n_chk++;
        if (out_valid_o !== 1'b0) $display("FAIL flush_drop got %b exp 0", out_valid_o);
        else n_pass++;
        flush_i = 1'b0; out_ready_i = 1'b0;
        tick();
        flush_i = 1'b1; in_valid_i = 1'b0;
        tick();
        n_chk++;
        if (out_valid_o !== 1'b0) $display("FAIL flush_stalled got %b exp 0", out_valid_o);
        else n_pass++;
        flush_i = 1'b0; out_ready_i = 1'b1; in_valid_i = 1'b1;
        inst_i = {6'h3F, 26'h2A_5A5A5};
        #1;
        n_chk++;
        if ({reg1_read_en_o, reg2_read_en_o} !== 2'b00)
            $display("FAIL invalid_read_en got %b%b exp 00", reg1_read_en_o, reg2_read_en_o);
        else n_pass++;
        tick();
        n_chk++;
        if ({out_valid_o, inst_invalid_o, write_reg_en_o, alu_sel_o} !== {1'b1, 1'b1, 1'b0, 3'b000} || obs !== exp_r)
            $display("FAIL invalid_opcode got v=%b inv=%b we=%b sel=%b exp 1/1/0/000",
                     out_valid_o, inst_invalid_o, write_reg_en_o, alu_sel_o);
        else n_pass++;
        in_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 63) != 0);
            flush_i     = ($urandom_range(0, 15) == 0);
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            inst_i      = gen_inst();
            pc_i        = $urandom;
            ex_wen_i    = 1'($urandom_range(0, 1));
            ex_waddr_i  = 5'($urandom_range(0, 3));
            ex_wdata_i  = $urandom;
            mem_wen_i   = 1'($urandom_range(0, 1));
            mem_waddr_i = 5'($urandom_range(0, 3));
            mem_wdata_i = $urandom;
            rf[$urandom_range(1, 7)] = $urandom;
            #1;
            n_chk++;
            if (in_ready_o !== model_ready() || reg1_read_addr_o !== inst_i[25:21] || reg2_read_addr_o !== inst_i[20:16])
                $display("FAIL rand_comb[%0d] got rdy=%b a1=%0d a2=%0d exp rdy=%b a1=%0d a2=%0d", i,
                         in_ready_o, reg1_read_addr_o, reg2_read_addr_o, model_ready(), inst_i[25:21], inst_i[20:16]);
            else n_pass++;
            tick();
            n_chk++;
            if (obs !== exp_r) $display("FAIL rand_idex[%0d] got %h exp %h", i, obs, exp_r);
            else n_pass++;
        end
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = $urandom;
        rf[0] = 32'hDEAD_BEEF;
        test_reset();
        test_ori();
        test_stall();
        test_forward();
        test_flush_invalid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
